// File: rtl/fft_sdf_stage_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fft_sdf_stage_ctrl                                            |
// | Purpose  : Control unit for one radix-2 SDF FFT stage (span HALF):       |
// |            butterfly enable, twiddle index, delay-line shift, out mux.   |
// | Options  : FFT_CTRL_FRAME_ERR_EN - stalls in FILL/BFLY abort the frame   |
// |            and set a sticky err flag.                                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fft_sdf_stage_ctrl #(
    parameter int DW      = 16,
    parameter int HALF    = 4,
    parameter int TW_STEP = 1,
    parameter int TW_W    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [DW-1:0]   data_in_r,
    input  logic [DW-1:0]   data_in_i,
    output logic            valid_o,
    output logic [1:0]      state,
    output logic            out_sel,
    output logic            bfly_en,
    output logic            shift_en,
    output logic [TW_W-1:0] tw_idx,
    output logic [DW:0]     data_out_r,
    output logic [DW:0]     data_out_i,
    output logic            err
);

    localparam int            IW     = $clog2(HALF) + 1;
    localparam logic [IW-1:0] C_LAST = IW'(HALF - 1);
    localparam logic [IW-1:0] C_HALF = IW'(HALF);
    localparam logic [IW-1:0] C_ONE  = IW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FILL  = 2'b01,
        S_BFLY  = 2'b10,
        S_DRAIN = 2'b11
    } state_t;

    state_t          st_q, st_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   hl_q, hl_d;
    logic            valid_d, out_sel_d, bfly_d, shift_d;
    logic [TW_W-1:0] tw_d;
`ifdef FFT_CTRL_FRAME_ERR_EN
    logic            err_q, err_set;
`endif

    always_comb begin
        st_d      = st_q;
        idx_d     = idx_q;
        hl_d      = hl_q;
        valid_d   = 1'b0;
        out_sel_d = 1'b0;
        bfly_d    = 1'b0;
        shift_d   = 1'b0;
        tw_d      = tw_idx;
`ifdef FFT_CTRL_FRAME_ERR_EN
        err_set   = 1'b0;
`endif
        case (st_q)
            S_IDLE: begin
                if (valid_i) begin
                    shift_d = 1'b1;
                    st_d    = S_FILL;
                    idx_d   = C_ONE;
                end
            end
            S_FILL: begin
                if (valid_i) begin
                    shift_d = 1'b1;
                    valid_d = (hl_q != '0);
                    if (hl_q != '0) hl_d = hl_q - C_ONE;
                    if (idx_q == C_LAST) begin
                        st_d  = S_BFLY;
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + C_ONE;
                    end
                end else if (idx_q == '0) begin
                    // FILL idx 0 is only reached straight after a butterfly phase:
                    // no follow-on sample means the stage starts draining now.
                    shift_d = 1'b1;
                    valid_d = 1'b1;
                    hl_d    = hl_q - C_ONE;
                    st_d    = S_DRAIN;
                end else begin
`ifdef FFT_CTRL_FRAME_ERR_EN
                    err_set = 1'b1;
                    st_d    = S_IDLE;
                    idx_d   = '0;
                    hl_d    = '0;
`endif
                end
            end
            S_BFLY: begin
                if (valid_i) begin
                    shift_d   = 1'b1;
                    bfly_d    = 1'b1;
                    out_sel_d = 1'b1;
                    valid_d   = 1'b1;
                    tw_d      = TW_W'(TW_W'(idx_q) * TW_W'(TW_STEP));
                    if (idx_q == C_LAST) begin
                        hl_d  = C_HALF;
                        st_d  = S_FILL;
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + C_ONE;
                    end
                end else begin
`ifdef FFT_CTRL_FRAME_ERR_EN
                    err_set = 1'b1;
                    st_d    = S_IDLE;
                    idx_d   = '0;
                    hl_d    = '0;
`endif
                end
            end
            S_DRAIN: begin
                shift_d = 1'b1;
                valid_d = 1'b1;
                hl_d    = hl_q - C_ONE;
                if (valid_i) begin
                    st_d  = S_FILL;
                    idx_d = C_ONE;
                end else if (hl_q == C_ONE) begin
                    st_d  = S_IDLE;
                    idx_d = '0;
                end
            end
            default: begin
                st_d  = S_IDLE;
                idx_d = '0;
                hl_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q       <= S_IDLE;
            idx_q      <= '0;
            hl_q       <= '0;
            valid_o    <= 1'b0;
            out_sel    <= 1'b0;
            bfly_en    <= 1'b0;
            shift_en   <= 1'b0;
            tw_idx     <= '0;
            data_out_r <= '0;
            data_out_i <= '0;
        end else begin
            st_q       <= st_d;
            idx_q      <= idx_d;
            hl_q       <= hl_d;
            valid_o    <= valid_d;
            out_sel    <= out_sel_d;
            bfly_en    <= bfly_d;
            shift_en   <= shift_d;
            tw_idx     <= tw_d;
            data_out_r <= {data_in_r[DW-1], data_in_r};
            data_out_i <= {data_in_i[DW-1], data_in_i};
        end
    end

    assign state = st_q;

`ifdef FFT_CTRL_FRAME_ERR_EN
    always_ff @(posedge clk) begin
        if (!rst) err_q <= 1'b0;
        else if (err_set) err_q <= 1'b1;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_sdf_stage_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fft_sdf_stage_ctrl                                         |
// | Purpose  : Directed self-checking bench for fft_sdf_stage_ctrl (HALF=4). |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fft_sdf_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_i = 1'b0;
    logic [15:0] data_in_r = '0;
    logic [15:0] data_in_i = '0;
    logic        valid_o, out_sel, bfly_en, shift_en, err;
    logic [1:0]  state;
    logic [3:0]  tw_idx;
    logic [16:0] data_out_r, data_out_i;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fft_sdf_stage_ctrl #(.DW(16), .HALF(4), .TW_STEP(1), .TW_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid_i),
        .data_in_r (data_in_r),
        .data_in_i (data_in_i),
        .valid_o   (valid_o),
        .state     (state),
        .out_sel   (out_sel),
        .bfly_en   (bfly_en),
        .shift_en  (shift_en),
        .tw_idx    (tw_idx),
        .data_out_r(data_out_r),
        .data_out_i(data_out_i),
        .err       (err)
    );

    // One sample per call; outputs are sampled 1 ns after the edge.
    task automatic drive(input logic v, input logic [15:0] d);
        valid_i   = v;
        data_in_r = d;
        data_in_i = ~d;
        @(posedge clk);
        #1;
    endtask

    task automatic drain4();
        for (int k = 0; k < 4; k++) drive(1'b0, 16'h0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b1, 16'h1234);
        drive(1'b1, 16'h1234);
        checks++;
        if ({valid_o, out_sel, bfly_en, shift_en, err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctl got=%b exp=00000", {valid_o, out_sel, bfly_en, shift_en, err});
        end
        checks++;
        if ({state, tw_idx, data_out_r, data_out_i} !== '0) begin
            failures++;
            $display("FAIL reset_regs state=%0d tw=%0d dr=%h di=%h exp all 0", state, tw_idx, data_out_r, data_out_i);
        end
        rst = 1'b1;
    endtask

    task automatic test_single_frame();
        logic [3:0] exp_ctl;
        logic [1:0] exp_st;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 16'(i));
            exp_ctl = (i <= 4) ? 4'b0001 : 4'b1111;
            exp_st  = (i < 4 || i == 8) ? 2'd1 : 2'd2;
            checks++;
            if ({valid_o, out_sel, bfly_en, shift_en} !== exp_ctl || state !== exp_st) begin
                failures++;
                $display("FAIL frame_ctl s%0d got=%b st=%0d exp=%b st=%0d", i, {valid_o, out_sel, bfly_en, shift_en}, state, exp_ctl, exp_st);
            end
            checks++;
            if (data_out_r !== 17'(i) || data_out_i !== {1'b1, ~16'(i)}) begin
                failures++;
                $display("FAIL frame_data s%0d got=%h/%h exp=%h/%h", i, data_out_r, data_out_i, 17'(i), {1'b1, ~16'(i)});
            end
            if (i > 4) begin
                checks++;
                if (tw_idx !== 4'(i - 5)) begin
                    failures++;
                    $display("FAIL frame_tw s%0d got=%0d exp=%0d", i, tw_idx, i - 5);
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 16'h0);
            exp_st = (k < 3) ? 2'd3 : 2'd0;
            checks++;
            if ({valid_o, out_sel, bfly_en, shift_en} !== 4'b1001 || state !== exp_st) begin
                failures++;
                $display("FAIL drain_ctl c%0d got=%b st=%0d exp=1001 st=%0d", k, {valid_o, out_sel, bfly_en, shift_en}, state, exp_st);
            end
        end
        drive(1'b0, 16'h0);
        checks++;
        if ({valid_o, shift_en, state} !== 4'b0000) begin
            failures++;
            $display("FAIL idle_after_drain got v=%b sh=%b st=%0d exp 0 0 0", valid_o, shift_en, state);
        end
    endtask

    task automatic test_back_to_back();
        int  nvalid = 0;
        bit  drain_seen = 0;
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 16'(i));
            if (state === 2'd3) drain_seen = 1;
            if (i > 4 && valid_o === 1'b1) nvalid++;
            if (i >= 9 && i <= 12) begin
                checks++;
                if ({valid_o, out_sel, bfly_en, shift_en} !== 4'b1001) begin
                    failures++;
                    $display("FAIL b2b_fill s%0d got=%b exp=1001", i, {valid_o, out_sel, bfly_en, shift_en});
                end
            end
        end
        checks++;
        if (drain_seen) begin
            failures++;
            $display("FAIL b2b_no_drain got=DRAIN seen exp=not seen");
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 16'h0);
            if (valid_o === 1'b1) nvalid++;
        end
        checks++;
        if (nvalid != 16 || state !== 2'd0) begin
            failures++;
            $display("FAIL b2b_count got=%0d st=%0d exp=16 st=0", nvalid, state);
        end
    endtask

    task automatic test_drain_restart();
        logic [3:0] exp_ctl;
        for (int i = 1; i <= 8; i++) drive(1'b1, 16'(i));
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 16'h0);
            checks++;
            if ({valid_o, out_sel, bfly_en, shift_en} !== 4'b1001 || state !== 2'd3) begin
                failures++;
                $display("FAIL restart_drain c%0d got=%b st=%0d exp=1001 st=3", k, {valid_o, out_sel, bfly_en, shift_en}, state);
            end
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'(i + 32));
            exp_ctl = (i < 2) ? 4'b1001 : ((i < 4) ? 4'b0001 : 4'b1111);
            checks++;
            if ({valid_o, out_sel, bfly_en, shift_en} !== exp_ctl) begin
                failures++;
                $display("FAIL restart_f2 s%0d got=%b exp=%b", i, {valid_o, out_sel, bfly_en, shift_en}, exp_ctl);
            end
        end
        drain4();
        checks++;
        if (state !== 2'd0) begin
            failures++;
            $display("FAIL restart_end st got=%0d exp=0", state);
        end
    endtask

`ifndef FFT_CTRL_FRAME_ERR_EN
    task automatic test_stall();
        drive(1'b1, 16'd1);
        drive(1'b1, 16'd2);
        drive(1'b0, 16'h0055);
        checks++;
        if ({valid_o, shift_en, state} !== 4'b0001 || data_out_r !== 17'h00055) begin
            failures++;
            $display("FAIL fill_stall got v=%b sh=%b st=%0d d=%h exp 0 0 1 00055", valid_o, shift_en, state, data_out_r);
        end
        for (int i = 3; i <= 6; i++) drive(1'b1, 16'(i));
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 16'(16'h00A0 + k));
            checks++;
            if ({valid_o, out_sel, bfly_en, shift_en} !== 4'b0000 || tw_idx !== 4'd1 || state !== 2'd2
                || data_out_r !== 17'(16'h00A0 + k)) begin
                failures++;
                $display("FAIL bfly_stall c%0d got=%b tw=%0d st=%0d d=%h exp=0000 tw=1 st=2 d=%h",
                         k, {valid_o, out_sel, bfly_en, shift_en}, tw_idx, state, data_out_r, 17'(16'h00A0 + k));
            end
        end
        drive(1'b1, 16'd7);
        checks++;
        if ({valid_o, out_sel, bfly_en, shift_en} !== 4'b1111 || tw_idx !== 4'd2) begin
            failures++;
            $display("FAIL stall_resume got=%b tw=%0d exp=1111 tw=2", {valid_o, out_sel, bfly_en, shift_en}, tw_idx);
        end
        drive(1'b1, 16'd8);
        checks++;
        if (tw_idx !== 4'd3 || err !== 1'b0) begin
            failures++;
            $display("FAIL stall_last got tw=%0d err=%b exp tw=3 err=0", tw_idx, err);
        end
        drain4();
        checks++;
        if (state !== 2'd0) begin
            failures++;
            $display("FAIL stall_end st got=%0d exp=0", state);
        end
    endtask
`else
    task automatic test_frame_err();
        for (int i = 1; i <= 6; i++) drive(1'b1, 16'(i));
        drive(1'b0, 16'h0);
        checks++;
        if ({err, valid_o, shift_en, state} !== 5'b10000) begin
            failures++;
            $display("FAIL err_set got e=%b v=%b sh=%b st=%0d exp 1 0 0 0", err, valid_o, shift_en, state);
        end
        drive(1'b0, 16'h0);
        drive(1'b1, 16'h9);
        checks++;
        if (err !== 1'b1 || state !== 2'd1) begin
            failures++;
            $display("FAIL err_sticky got e=%b st=%0d exp e=1 st=1", err, state);
        end
        rst = 1'b0;
        drive(1'b0, 16'h0);
        rst = 1'b1;
        checks++;
        if (err !== 1'b0 || state !== 2'd0) begin
            failures++;
            $display("FAIL err_clear got e=%b st=%0d exp e=0 st=0", err, state);
        end
    endtask
`endif

    task automatic test_reset_drain();
        for (int i = 1; i <= 8; i++) drive(1'b1, 16'(i));
        drive(1'b0, 16'h0);
        checks++;
        if (state !== 2'd3) begin
            failures++;
            $display("FAIL rstdrain_pre st got=%0d exp=3", state);
        end
        rst = 1'b0;
        drive(1'b0, 16'h0);
        rst = 1'b1;
        checks++;
        if ({valid_o, out_sel, bfly_en, shift_en, err, state, tw_idx} !== '0) begin
            failures++;
            $display("FAIL rstdrain_outs got ctl=%b st=%0d tw=%0d exp all 0", {valid_o, out_sel, bfly_en, shift_en, err}, state, tw_idx);
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 16'h0);
            checks++;
            if (valid_o !== 1'b0 || state !== 2'd0) begin
                failures++;
                $display("FAIL rstdrain_quiet c%0d got v=%b st=%0d exp v=0 st=0", k, valid_o, state);
            end
        end
    endtask

    task automatic test_sign_ext();
        drive(1'b1, 16'h0001);
        valid_i   = 1'b1;
        data_in_r = 16'h8000;
        data_in_i = 16'h7FFF;
        #2;
        checks++;
        if (data_out_r !== 17'h00001) begin
            failures++;
            $display("FAIL sext_latency got=%h exp=00001", data_out_r);
        end
        @(posedge clk);
        #1;
        checks++;
        if (data_out_r !== 17'h18000 || data_out_i !== 17'h07FFF) begin
            failures++;
            $display("FAIL sext_value got=%h/%h exp=18000/07fff", data_out_r, data_out_i);
        end
        valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_drain_restart();
`ifndef FFT_CTRL_FRAME_ERR_EN
        test_stall();
`else
        test_frame_err();
`endif
        test_reset_drain();
        test_sign_ext();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
